// File: rtl/rv32i_exec_core.sv
// RV32I decode/execute datapath: combinational decoder, 32x32 register file
// with asynchronous reads, and a single-cycle registered ALU.
module rv32i_exec_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] insn,
   output logic [4:0]  opcode,
   output logic [3:0]  alu_op,
   output logic        invalid,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] imm,
   input  logic        rden,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        wren,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  alu_op_in,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   output logic [31:0] alu_out
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned RAW   = 5;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   logic [RAW-1:0]  f_rd, f_rs1, f_rs2;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = insn[6:2];
   assign f_rd   = insn[11:7];
   assign f_rs1  = insn[19:15];
   assign f_rs2  = insn[24:20];
   assign funct3 = insn[14:12];

   assign imm_i = {{20{insn[31]}}, insn[31:20]};
   assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u = {insn[31:12], 12'b0};
   assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

   // Decoder: unused register fields are forced to 0 so the sequencer can rely on them
   always_comb begin
      invalid = 1'b1;
      rd      = '0;
      rs1     = '0;
      rs2     = '0;
      imm     = '0;
      alu_op  = ALU_ADD;
      if (insn[1:0] == 2'b11) begin
         invalid = 1'b0;
         case (opcode)
            OPC_LUI, OPC_AUIPC: begin
               rd  = f_rd;
               imm = imm_u;
            end
            OPC_JAL: begin
               rd  = f_rd;
               imm = imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
               rd  = f_rd;
               rs1 = f_rs1;
               imm = imm_i;
            end
            OPC_MISC_MEM: begin
               rs1 = f_rs1;
               imm = imm_i;
            end
            OPC_BRANCH: begin
               rs1    = f_rs1;
               rs2    = f_rs2;
               imm    = imm_b;
               alu_op = ALU_SUB;
            end
            OPC_STORE: begin
               rs1 = f_rs1;
               rs2 = f_rs2;
               imm = imm_s;
            end
            OPC_OP_IMM: begin
               rd     = f_rd;
               rs1    = f_rs1;
               imm    = imm_i;
               alu_op = {(funct3 == 3'b101) ? insn[30] : 1'b0, funct3};
            end
            OPC_OP: begin
               rd     = f_rd;
               rs1    = f_rs1;
               rs2    = f_rs2;
               alu_op = {insn[30], funct3};
            end
            default: invalid = 1'b1;
         endcase
      end
   end

   logic [XLEN-1:0] regs_q [NREGS];

   // Register file: x0 is never written; reset wins over a concurrent write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      end else if (wren && (wr_addr != '0)) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   assign rs1_data = (rden && (rs1 != '0)) ? regs_q[rs1] : '0;
   assign rs2_data = (rden && (rs2 != '0)) ? regs_q[rs2] : '0;

   logic [XLEN-1:0] alu_d, alu_q;
   logic [4:0]      shamt;

   assign shamt = alu_b[4:0];

   always_comb begin
      alu_d = '0;
      case (alu_op_in)
         ALU_ADD:  alu_d = alu_a + alu_b;
         ALU_SUB:  alu_d = alu_a - alu_b;
         ALU_SLL:  alu_d = alu_a << shamt;
         ALU_SLT:  alu_d = XLEN'($signed(alu_a) < $signed(alu_b));
         ALU_SLTU: alu_d = XLEN'(alu_a < alu_b);
         ALU_XOR:  alu_d = alu_a ^ alu_b;
         ALU_SRL:  alu_d = alu_a >> shamt;
         ALU_SRA:  alu_d = XLEN'($signed(alu_a) >>> shamt);
         ALU_OR:   alu_d = alu_a | alu_b;
         ALU_AND:  alu_d = alu_a & alu_b;
         default:  alu_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) alu_q <= '0;
      else     alu_q <= alu_d;
   end

   assign alu_out = alu_q;

endmodule

// File: tb/tb_rv32i_exec_core.sv
// Directed testbench for rv32i_exec_core: decode fields, register file and ALU latency.
module tb_rv32i_exec_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] insn;
   logic [4:0]  opcode;
   logic [3:0]  alu_op;
   logic        invalid;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;
   logic        rden;
   logic [31:0] rs1_data, rs2_data;
   logic        wren;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  alu_op_in;
   logic [31:0] alu_a, alu_b;
   logic [31:0] alu_out;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   rv32i_exec_core dut (
      .clk(clk), .rst(rst), .insn(insn), .opcode(opcode), .alu_op(alu_op),
      .invalid(invalid), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .rden(rden), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
      .alu_op_in(alu_op_in), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
   );

   // R-type ADD with chosen source fields, used to steer the register read ports
   function automatic logic [31:0] op_rr(input logic [4:0] a, input logic [4:0] b);
      return {7'b0, b, a, 3'b000, 5'd0, 7'b0110011};
   endfunction

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wren = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wren = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; wren = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA5555;
      alu_op_in = 4'b0000; alu_a = 32'd1; alu_b = 32'd1;
      rden = 1'b1; insn = op_rr(5'd5, 5'd31);
      @(posedge clk); #1;
      vecs++; if (alu_out !== 32'h0) begin errs++; $display("FAIL rst_alu got %h exp %h", alu_out, 32'h0); end
      @(negedge clk);
      rst = 1'b0; wren = 1'b0;
      #1;
      vecs++; if (rs1_data !== 32'h0) begin errs++; $display("FAIL rst_rs1 got %h exp %h", rs1_data, 32'h0); end
      vecs++; if (rs2_data !== 32'h0) begin errs++; $display("FAIL rst_rs2 got %h exp %h", rs2_data, 32'h0); end
      @(posedge clk); #1;
      vecs++; if (alu_out !== 32'd2) begin errs++; $display("FAIL rst_release_alu got %h exp %h", alu_out, 32'd2); end
   endtask

   task automatic test_regfile();
      wr_reg(5'd3, 32'hDEADBEEF);
      wr_reg(5'd0, 32'h00001234);
      insn = op_rr(5'd3, 5'd0); rden = 1'b1; #1;
      vecs++; if (rs1_data !== 32'hDEADBEEF) begin errs++; $display("FAIL rf_x3 got %h exp %h", rs1_data, 32'hDEADBEEF); end
      insn = op_rr(5'd0, 5'd3); #1;
      vecs++; if (rs1_data !== 32'h0) begin errs++; $display("FAIL rf_x0 got %h exp %h", rs1_data, 32'h0); end
      vecs++; if (rs2_data !== 32'hDEADBEEF) begin errs++; $display("FAIL rf_rs2_x3 got %h exp %h", rs2_data, 32'hDEADBEEF); end
      rden = 1'b0; insn = op_rr(5'd3, 5'd3); #1;
      vecs++; if (rs1_data !== 32'h0) begin errs++; $display("FAIL rf_rden0_rs1 got %h exp %h", rs1_data, 32'h0); end
      vecs++; if (rs2_data !== 32'h0) begin errs++; $display("FAIL rf_rden0_rs2 got %h exp %h", rs2_data, 32'h0); end
      rden = 1'b1;
   endtask

   task automatic test_decode();
      insn = 32'hFFF00093; #1;
      vecs++; if (opcode !== 5'b00100) begin errs++; $display("FAIL addi_opcode got %b exp %b", opcode, 5'b00100); end
      vecs++; if (rd !== 5'd1) begin errs++; $display("FAIL addi_rd got %0d exp %0d", rd, 1); end
      vecs++; if (rs1 !== 5'd0) begin errs++; $display("FAIL addi_rs1 got %0d exp %0d", rs1, 0); end
      vecs++; if (rs2 !== 5'd0) begin errs++; $display("FAIL addi_rs2 got %0d exp %0d", rs2, 0); end
      vecs++; if (imm !== 32'hFFFFFFFF) begin errs++; $display("FAIL addi_imm got %h exp %h", imm, 32'hFFFFFFFF); end
      vecs++; if (alu_op !== 4'b0000) begin errs++; $display("FAIL addi_aluop got %b exp %b", alu_op, 4'b0000); end
      vecs++; if (invalid !== 1'b0) begin errs++; $display("FAIL addi_invalid got %b exp %b", invalid, 1'b0); end
      insn = 32'h40208133; #1;
      vecs++; if (alu_op !== 4'b1000) begin errs++; $display("FAIL sub_aluop got %b exp %b", alu_op, 4'b1000); end
      vecs++; if ({rd, rs1, rs2} !== {5'd2, 5'd1, 5'd2}) begin errs++; $display("FAIL sub_regs got %0d/%0d/%0d exp 2/1/2", rd, rs1, rs2); end
      vecs++; if (imm !== 32'h0) begin errs++; $display("FAIL sub_imm got %h exp %h", imm, 32'h0); end
      insn = 32'h40315093; #1;
      vecs++; if (alu_op !== 4'b1101) begin errs++; $display("FAIL srai_aluop got %b exp %b", alu_op, 4'b1101); end
      vecs++; if (imm !== 32'h00000403) begin errs++; $display("FAIL srai_imm got %h exp %h", imm, 32'h403); end
      insn = 32'h00208463; #1;
      vecs++; if (alu_op !== 4'b1000) begin errs++; $display("FAIL beq_aluop got %b exp %b", alu_op, 4'b1000); end
      vecs++; if (imm !== 32'd8) begin errs++; $display("FAIL beq_imm got %h exp %h", imm, 32'd8); end
      vecs++; if ({rd, rs1, rs2} !== {5'd0, 5'd1, 5'd2}) begin errs++; $display("FAIL beq_regs got %0d/%0d/%0d exp 0/1/2", rd, rs1, rs2); end
      insn = 32'h00000000; #1;
      vecs++; if (invalid !== 1'b1) begin errs++; $display("FAIL zero_invalid got %b exp %b", invalid, 1'b1); end
      insn = 32'hFFF00090; #1;
      vecs++; if ({invalid, rd, rs1, rs2, imm, alu_op} !== {1'b1, 15'd0, 32'd0, 4'd0}) begin
         errs++; $display("FAIL lowbits_invalid got inv=%b rd=%0d imm=%h exp inv=1 rd=0 imm=0", invalid, rd, imm);
      end
   endtask

   task automatic test_imm();
      insn = 32'h0080006F; #1;
      vecs++; if (imm !== 32'd8) begin errs++; $display("FAIL jal_imm got %h exp %h", imm, 32'd8); end
      vecs++; if (rs1 !== 5'd0) begin errs++; $display("FAIL jal_rs1 got %0d exp %0d", rs1, 0); end
      insn = 32'h123452B7; #1;
      vecs++; if (imm !== 32'h12345000) begin errs++; $display("FAIL lui_imm got %h exp %h", imm, 32'h12345000); end
      vecs++; if (rd !== 5'd5) begin errs++; $display("FAIL lui_rd got %0d exp %0d", rd, 5); end
      vecs++; if (rs1 !== 5'd0) begin errs++; $display("FAIL lui_rs1 got %0d exp %0d", rs1, 0); end
      insn = 32'hFE112E23; #1;
      vecs++; if (imm !== 32'hFFFFFFFC) begin errs++; $display("FAIL sw_imm got %h exp %h", imm, 32'hFFFFFFFC); end
      vecs++; if ({rd, rs1, rs2} !== {5'd0, 5'd2, 5'd1}) begin errs++; $display("FAIL sw_regs got %0d/%0d/%0d exp 0/2/1", rd, rs1, rs2); end
   endtask

   task automatic test_alu();
      logic [3:0]  ops  [9] = '{4'b0000, 4'b1101, 4'b0010, 4'b0011, 4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1001};
      logic [31:0] as   [9] = '{32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd1, 32'h80000000, 32'h12345678};
      logic [31:0] bs   [9] = '{32'd6, 32'd4, 32'd1, 32'd1, 32'd1, 32'd5, 32'h21, 32'd4, 32'h1};
      logic [31:0] exps [9] = '{32'd11, 32'hF8000000, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFE, 32'd2, 32'h08000000, 32'd0};
      logic [31:0] prev;
      prev = 32'hx;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         alu_op_in = ops[i]; alu_a = as[i]; alu_b = bs[i];
         #1;
         if (i > 0) begin
            vecs++; if (alu_out !== prev) begin errs++; $display("FAIL alu_hold%0d got %h exp %h", i, alu_out, prev); end
         end
         @(posedge clk); #1;
         vecs++; if (alu_out !== exps[i]) begin errs++; $display("FAIL alu_op%0d got %h exp %h", i, alu_out, exps[i]); end
         prev = exps[i];
      end
   endtask

   task automatic test_back_to_back();
      wr_reg(5'd7, 32'd5);
      @(negedge clk);
      insn = op_rr(5'd7, 5'd7); rden = 1'b1;
      wren = 1'b1; wr_addr = 5'd7; wr_data = 32'd9;
      #1;
      vecs++; if (rs1_data !== 32'd5) begin errs++; $display("FAIL rw_same_old got %h exp %h", rs1_data, 32'd5); end
      @(posedge clk); #1;
      vecs++; if (rs2_data !== 32'd9) begin errs++; $display("FAIL rw_same_new got %h exp %h", rs2_data, 32'd9); end
      @(negedge clk);
      wren = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst = 1'b1; wren = 1'b1; wr_addr = 5'd3; wr_data = 32'h55555555;
      @(negedge clk);
      rst = 1'b0; wren = 1'b0;
      insn = op_rr(5'd3, 5'd7); #1;
      vecs++; if (rs1_data !== 32'h0) begin errs++; $display("FAIL midrst_x3 got %h exp %h", rs1_data, 32'h0); end
      vecs++; if (rs2_data !== 32'h0) begin errs++; $display("FAIL midrst_x7 got %h exp %h", rs2_data, 32'h0); end
   endtask

   initial begin
      rst = 1'b0; insn = '0; rden = 1'b0; wren = 1'b0; wr_addr = '0; wr_data = '0;
      alu_op_in = '0; alu_a = '0; alu_b = '0;
      test_reset();
      test_regfile();
      test_decode();
      test_imm();
      test_alu();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/rv32i_exec_core.md
# rv32i_exec_core

Combined RV32I instruction decoder, 32×32 register file and registered ALU forming the decode/execute datapath of the multi-cycle CPU. The sequencer supplies the fetched instruction word, read/write enables and ALU operands, and drives PC, fetch and write-back muxing. It sits between instruction ROM and the write-back mux.

## Interface
- No parameters (XLEN fixed at 32, 32 architectural registers).
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- insn  in  32  instruction word to decode
- opcode  out  5  insn[6:2]
- alu_op  out  4  decoded ALU operation
- invalid  out  1  instruction not a supported RV32I encoding
- rd  out  5  destination register, forced 0 when no write
- rs1  out  5  source register 1, forced 0 when unused
- rs2  out  5  source register 2, forced 0 when unused
- imm  out  32  sign-extended immediate
- rden  in  1  register read enable
- rs1_data  out  32  value of register rs1
- rs2_data  out  32  value of register rs2
- wren  in  1  register write enable
- wr_addr  in  5  write address
- wr_data  in  32  write data
- alu_op_in  in  4  ALU operation to execute
- alu_a  in  32  ALU operand A
- alu_b  in  32  ALU operand B
- alu_out  out  32  registered ALU result

## Operation
- Decode is purely combinational from insn.
- Valid opcodes (insn[1:0] must be 2'b11): LUI 01101, AUIPC 00101, JAL 11011, JALR 11001, BRANCH 11000, LOAD 00000, STORE 01000, OP-IMM 00100, OP 01100, MISC-MEM 00011, SYSTEM 11100. Anything else: invalid=1, rd=rs1=rs2=0, imm=0, alu_op=0.
- Register fields: rd=insn[11:7], rs1=insn[19:15], rs2=insn[24:20].
  - rd=0 for BRANCH, STORE, MISC-MEM.
  - rs1=0 for LUI, AUIPC, JAL.
  - rs2=0 for all except OP, BRANCH, STORE.
- Immediates, sign bit insn[31]:
  - I-type (LOAD, OP-IMM, JALR, SYSTEM, MISC-MEM): insn[31:20].
  - S: {insn[31:25],insn[11:7]}.
  - B: {insn[31],insn[7],insn[30:25],insn[11:8],0}.
  - U: {insn[31:12],12'b0}.
  - J: {insn[31],insn[19:12],insn[20],insn[30:21],0}.
  - OP: 0.
- alu_op:
  - OP: {insn[30],funct3}.
  - OP-IMM: {funct3==3'b101 ? insn[30] : 0, funct3}.
  - BRANCH: 1000 (SUB).
  - All others: 0000 (ADD).
- ALU encodings:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Unlisted codes yield 0.
  - Shifts use alu_b[4:0]; arithmetic wraps mod 2^32; SLT/SLTU produce 0 or 1.
- Register file:
  - Reads asynchronous: rsN_data = rden ? x[rsN] : 0.
  - x0 always reads 0.
  - Writes on posedge when wren=1 and wr_addr≠0; writes to x0 ignored.
  - Read and write of the same register in the same cycle returns the old value (no bypass).

## Timing
- Decode: 0 cycles.
- Register read: 0 cycles.
- Register write: visible on reads after the write edge.
- ALU: 1 cycle; alu_out registered at each posedge from the operands present that cycle. There is no enable, so the result updates every cycle.
- Reset at any cycle (including mid-instruction): on the rst edge all 32 registers clear to 0 and alu_out clears to 0. Writes are suppressed in that cycle even if wren=1.
- Decode outputs do not depend on rst.

## Test plan
- Reset then read: assert rst one cycle, rden=1, rs1=5, rs2=31 → rs1_data=rs2_data=0, alu_out=0.
- Write/read:
  - wren, wr_addr=3, wr_data=0xDEADBEEF, then read rs1=3 → 0xDEADBEEF.
  - Write 0x1234 to x0 → x0 reads 0.
  - rden=0 → outputs 0.
- Decode:
  - insn 0xFFF00093 (addi x1,x0,-1) → opcode 00100, rd=1, rs1=0, imm=0xFFFFFFFF, alu_op 0000, invalid=0.
  - insn 0x40208133 (sub x2,x1,x2) → alu_op 1000, rs2=2.
  - insn 0x00000000 → invalid=1.
- Immediates:
  - JAL 0x0080006F → imm=8, rs1=0.
  - LUI 0x123452B7 → imm=0x12345000, rd=5.
  - SW 0xFE112E23 → imm=0xFFFFFFFC, rd=0.
- ALU, one-cycle latency:
  - SRA a=0x80000000 b=4 → 0xF8000000 next cycle.
  - SLT a=-1 b=1 → 1; SLTU same operands → 0.
  - ADD 0xFFFFFFFF+1 → 0.
- Simultaneous read/write to x7 (old 5, new 9) → read returns 5 that cycle, 9 after the edge.
